// File: rtl/req_debouncer_pkg.sv
// Shared constants and types for the request input conditioner and its consumers.
package req_debouncer_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 16;
    localparam int DEF_PRESCALE    = 1000;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_kind_t;

    // Bits needed to hold values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/req_debouncer_channel.sv
// One debounced bit: synchroniser chain, stability counter, clean level and edge strobes.
module req_debouncer_channel
    import req_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int CNT_W       = cnt_width(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic adv,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic accept
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    edge_kind_t             kind;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // The new level is accepted on the advance that would complete DB_CYCLES differing advances.
    always_comb begin
        accept = 1'b0;
        kind   = EDGE_NONE;
        if (adv && (s != dout) && (cnt == CNT_W'(DB_CYCLES - 1))) begin
            accept = 1'b1;
            kind   = s ? EDGE_RISE : EDGE_FALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= (kind == EDGE_RISE);
            fall <= (kind == EDGE_FALL);
            if (adv) begin
                if ((s == dout) || accept) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (accept) begin
                    dout <= s;
                end
            end
        end
    end

endmodule

// File: rtl/req_debouncer.sv
// Multi-channel request debouncer with a shared any_change flag.
// Build option REQ_DEBOUNCER_PRESCALE_EN slows the stability counters with a shared prescaler tick.
module req_debouncer
    import req_debouncer_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES
`ifdef REQ_DEBOUNCER_PRESCALE_EN
    ,
    parameter int PRESCALE    = DEF_PRESCALE
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            any_change
);

    localparam int CNT_W = cnt_width(DB_CYCLES);

    logic            adv;
    logic [N_CH-1:0] accept;

`ifdef REQ_DEBOUNCER_PRESCALE_EN
    localparam int PS_W = cnt_width(PRESCALE);

    logic [PS_W-1:0] pre;

    assign adv = (pre == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (adv) begin
            pre <= '0;
        end else begin
            pre <= pre + PS_W'(1);
        end
    end
`else
    assign adv = 1'b1;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        req_debouncer_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .din    (din[i]),
            .adv    (adv),
            .dout   (dout[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .accept (accept[i])
        );
    end

    // Registered from the same accept terms as the strobes so it lines up with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |accept;
        end
    end

endmodule
